// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter and burst sequencer that owns the select lines of a
// shared 4:1 mux. One requester at a time is granted for a bounded burst.
// The selected leg is streamed to a single consumer over valid/ready.
//
// Parameters
//   W          data width of each mux leg and of y
//   MAX_BURST  accepted beats per grant before forced rotation (1..15)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   req[3:0]   request per requester (req[0]->d00 ... req[3]->d11)
//   d00..d11   requester data legs
//   ready      consumer accepts the current beat
//   lock       (MUX_ARB_LOCK_EN only) hold the grant past MAX_BURST
//   gnt[3:0]   one-hot grant, registered
//   s1, s0     mux selects, registered; {s1,s0} = owner index
//   valid      beat available on y (req of the current owner)
//   y          selected data, zero when not valid
//   busy       high while in GRANT
//
// Optional feature: define MUX_ARB_LOCK_EN to add the lock input.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; gnt=0, selects hold their last value
// GRANT | owner = {s1,s0}; beats counted in cnt until release
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] d00,
    input  logic [W-1:0] d01,
    input  logic [W-1:0] d10,
    input  logic [W-1:0] d11,
    input  logic         ready,
`ifdef MUX_ARB_LOCK_EN
    input  logic         lock,
`endif
    output logic [3:0]   gnt,
    output logic         s1,
    output logic         s0,
    output logic         valid,
    output logic [W-1:0] y,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t       state;
    logic [1:0]   ptr;
    logic [1:0]   sel;
    logic [3:0]   cnt;

    logic         beat;
    logic         at_last;
    logic         lock_hold;
    logic         release_now;
    logic [1:0]   ptr_rot;
    logic [1:0]   search_ptr;
    logic [2:0]   win;
    logic [W-1:0] y_mux;

    // First set bit of r searching upward from start, wrapping 3->0.
    // Returns {found, index}. Walking k downward lets the smallest
    // distance from start overwrite any farther hit.
    function automatic logic [2:0] pick(input logic [1:0] start,
                                        input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign s1   = sel[1];
    assign s0   = sel[0];
    assign busy = (state == GRANT);

    always_comb begin
        y_mux = d00;
        case (sel)
            2'b00:   y_mux = d00;
            2'b01:   y_mux = d01;
            2'b10:   y_mux = d10;
            default: y_mux = d11;
        endcase
    end

    assign valid = busy && req[sel];
    assign y     = valid ? y_mux : '0;

    assign beat    = valid && ready;
    assign at_last = (cnt == CNT_LAST);

`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Release on a dropped request, or on the last beat of the burst
    // unless the owner holds the lock.
    assign release_now = busy && (!req[sel] || (beat && at_last && !lock_hold));

    // On release the search starts just past the outgoing owner so it is
    // considered last; a lone requester is therefore re-granted in place.
    assign ptr_rot    = sel + 2'd1;
    assign search_ptr = release_now ? ptr_rot : ptr;
    assign win        = pick(search_ptr, req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            cnt   <= 4'd0;
            gnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win[2]) begin
                        state <= GRANT;
                        sel   <= win[1:0];
                        gnt   <= 4'b0001 << win[1:0];
                        cnt   <= 4'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= ptr_rot;
                        if (win[2]) begin
                            sel <= win[1:0];
                            gnt <= 4'b0001 << win[1:0];
                            cnt <= 4'd0;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'd0;
                        end
                    end else if (beat && !at_last) begin
                        // Saturates at the last count while locked.
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'd0;
                end
            endcase
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt));

    a_sel_matches_gnt : assert property (@(posedge clk) disable iff (rst)
        busy |-> (gnt == (4'b0001 << sel)));

    a_busy_iff_gnt : assert property (@(posedge clk) disable iff (rst)
        busy == (gnt != 4'd0));

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 multiplexer datapath between four requesters.
- Each requester raises `req[i]` and presents W-bit data on its mux leg (d00..d11).
- The block owns the mux selects (s1,s0), grants one requester at a time for a bounded burst, and streams the selected data to a single consumer using a valid/ready handshake.
- It sits directly in front of the existing 4x1 mux and drives its select lines.

Parameters:
- W, 8, data width of each mux leg and of y.
- MAX_BURST, 4, maximum accepted beats per grant before forced rotation (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  4  request per requester; req[0]→d00, req[1]→d01, req[2]→d10, req[3]→d11.
- d00  input  W  requester 0 data.
- d01  input  W  requester 1 data.
- d10  input  W  requester 2 data.
- d11  input  W  requester 3 data.
- ready  input  1  consumer accepts the current beat.
- gnt  output  4  one-hot grant, registered.
- s1  output  1  mux select MSB, registered; {s1,s0} = owner index.
- s0  output  1  mux select LSB, registered.
- valid  output  1  beat available on y.
- y  output  W  selected data.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (async, immediate, also mid-burst):
  - gnt=0, s1=s0=0, valid=0, y=0, busy=0.
  - State IDLE, priority pointer ptr=0, beat count cnt=0.
  - Any in-flight burst is abandoned with no completion.
- States: IDLE, GRANT.
- Selection rule: search req from ptr upward, wrapping 3→0. The first set bit becomes the owner.
- IDLE:
  - If req≠0 at a rising edge: select the owner, then gnt=onehot(owner), {s1,s0}=owner, cnt=0, go to GRANT.
  - Latency from req to gnt is exactly 1 cycle.
- GRANT outputs:
  - busy=1.
  - valid = req[owner] (combinational).
  - y = valid ? d[{s1,s0}] : 0 (combinational through the mux).
- Beat: valid && ready at a rising edge. On a beat, cnt increments.
- ready low stalls: cnt holds and the grant holds indefinitely while req[owner] stays high.
- Release conditions, evaluated at the rising edge:
  - (a) req[owner]=0, or
  - (b) a beat occurs with cnt==MAX_BURST-1.
- On release:
  - ptr = (owner+1) mod 4.
  - Re-arbitrate in the same edge using the new ptr and the current req; the released owner is searched last.
  - If a winner exists: gnt and selects move directly to it (back-to-back, no IDLE bubble), cnt=0.
  - Otherwise: gnt=0, selects hold their last value, go to IDLE.
- A lone requester that hits MAX_BURST is re-granted immediately (cnt=0), with no gap in gnt.
- Simultaneous requests: the winner is strictly decided by ptr. No requester waits more than 3 grants.
- MAX_BURST=1: every beat forces rotation.
- gnt is always one-hot or zero. {s1,s0} always matches the gnt index while busy=1.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- When defined:
  - Extra input `lock` (1 bit).
  - While in GRANT with lock=1, release condition (b) is suppressed: the burst continues past MAX_BURST, and cnt saturates at MAX_BURST-1.
  - Release condition (a) still applies.
  - When lock deasserts, the next beat with cnt==MAX_BURST-1 releases.
- When undefined: no lock port; rotation is always enforced.

Test Plan:
- Reset mid-burst: rst pulsed while gnt=4'b0100 → outputs go to 0 immediately, before the next edge; after release, first req=4'b0001 → gnt=4'b0001 one cycle later.
- Single requester: req=4'b0100, d10=8'hA5, ready=1 → gnt=4'b0100 and {s1,s0}=2'b10 after 1 cycle; y=8'hA5 with valid=1; after 4 beats, re-grant with gnt continuously high.
- Round robin: req=4'b1111, ready=1, MAX_BURST=4 → owners 0,1,2,3,0 in order, each for exactly 4 beats, with no idle cycle between grants.
- Stall: owner 1, ready=0 for 10 cycles → gnt holds, cnt unchanged; after ready=1, exactly 4 more beats are accepted before rotation.
- Early drop: owner 2 drops req after 2 beats while req[3]=1 → gnt=4'b1000 at the next edge; ptr skips to 3 and then 0.
- Lock (MUX_ARB_LOCK_EN): lock=1, req=4'b0011 → owner 0 gets 9 beats; lock falls → the next beat releases and gnt moves to 4'b0010.
